// File: rtl/uart_rx_sched.sv
// uart_rx_sched: baud enable generator, rx byte capture FSM and FWFT FIFO with sticky overrun.
module uart_rx_sched #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   div_wr,
    input  logic [DIV_W-1:0]       div_in,
    output logic                   brg_en,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   clr_rdy,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    input  logic                   ovr_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_CLR} state_t;
    state_t state, state_nxt;
    logic [DIV_W-1:0] div_q, brg_cnt;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_nxt;
    logic [7:0] last_q;
    logic push, pop, drop;
    assign brg_en = !rst && !div_wr && brg_cnt == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= DIV_RST;
            brg_cnt <= DIV_RST;
        end else if (div_wr) begin
            div_q   <= div_in;
            brg_cnt <= div_in;
        end else begin
            brg_cnt <= brg_cnt == '0 ? div_q : brg_cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        clr_rdy   = 1'b0;
        case (state)
            IDLE:     if (rx_rdy) state_nxt = CAPTURE;
            CAPTURE: begin
                clr_rdy   = 1'b1;
                state_nxt = WAIT_CLR;
            end
            WAIT_CLR: if (!rx_rdy) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
    // fullness and emptiness are judged on the registered pre-edge state
    assign push      = clr_rdy && !fifo_full;
    assign drop      = clr_rdy && fifo_full;
    assign pop       = rd_en && !fifo_empty;
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign rd_data   = fifo_empty ? last_q : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            last_q     <= '0;
            overrun    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_nxt;
            fifo_empty <= count_nxt == '0;
            fifo_full  <= count_nxt == CW'(DEPTH);
            last_q     <= rd_data;
            overrun    <= drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun);
        end
    end
endmodule

// File: tb/tb_uart_rx_sched.sv
// tb_uart_rx_sched: directed checks of baud generator, capture handshake and FIFO behaviour.
module tb_uart_rx_sched;
    logic clk = 1'b0, rst = 1'b1, div_wr = 1'b0, rx_rdy = 1'b0, rd_en = 1'b0, ovr_clr = 1'b0;
    logic [15:0] div_in = '0;
    logic [7:0] rx_data = '0, rd_data;
    logic brg_en, clr_rdy, fifo_empty, fifo_full, overrun;
    logic [2:0] count;
    int tests = 0, fails = 0;
    uart_rx_sched #(.DEPTH(4), .DIV_W(16), .DIV_RST(16'd1)) dut (
        .clk(clk), .rst(rst), .div_wr(div_wr), .div_in(div_in), .brg_en(brg_en),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rdy(clr_rdy), .rd_en(rd_en),
        .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .count(count), .overrun(overrun), .ovr_clr(ovr_clr)
    );
    always #5 clk = ~clk;
    // receiver model: raise rdy, drop it once clr_rdy is seen, then let the FSM return to IDLE
    task automatic send_byte(input logic [7:0] b);
        bit seen = 0;
        rx_rdy = 1'b1; rx_data = b;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = clr_rdy;
        end
        rx_rdy = 1'b0;
        tests++; if (!seen) begin fails++; $display("FAIL send_timeout got no clr_rdy exp clr_rdy for byte %h", b); end
        @(negedge clk); @(negedge clk);
    endtask
    task automatic pop_one();
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0; #1;
        tests++; if (brg_en !== 1'b0) begin fails++; $display("FAIL rst_brg got %b exp 0", brg_en); end
        tests++; if (clr_rdy !== 1'b0) begin fails++; $display("FAIL rst_clr got %b exp 0", clr_rdy); end
        tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %b exp 1", fifo_empty); end
        tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL rst_full got %b exp 0", fifo_full); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_ovr got %b exp 0", overrun); end
        tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL rst_rd_data got %h exp 00", rd_data); end
        @(negedge clk);
        tests++; if (brg_en !== 1'b1) begin fails++; $display("FAIL rst_brg_period got %b exp 1", brg_en); end
    endtask
    task automatic test_baud();
        int first = 0, second = 0, highs = 0;
        div_wr = 1'b1; div_in = 16'd15; #1;
        tests++; if (brg_en !== 1'b0) begin fails++; $display("FAIL baud_divwr_gate got %b exp 0", brg_en); end
        @(negedge clk); div_wr = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            #1;
            if (brg_en) begin
                highs++;
                if (first == 0) first = k; else if (second == 0) second = k;
            end
            @(negedge clk);
        end
        tests++; if (first !== 16) begin fails++; $display("FAIL baud_first got %0d exp 16", first); end
        tests++; if (second !== 32) begin fails++; $display("FAIL baud_second got %0d exp 32", second); end
        tests++; if (highs !== 2) begin fails++; $display("FAIL baud_highs got %0d exp 2", highs); end
        div_wr = 1'b1; div_in = 16'd0; @(negedge clk); div_wr = 1'b0;
        highs = 0;
        for (int k = 0; k < 3; k++) begin #1; highs += int'(brg_en); @(negedge clk); end
        tests++; if (highs !== 3) begin fails++; $display("FAIL baud_div0 got %0d exp 3", highs); end
    endtask
    task automatic test_single();
        rx_rdy = 1'b1; rx_data = 8'hA5;
        @(negedge clk);
        tests++; if (clr_rdy !== 1'b1) begin fails++; $display("FAIL single_clr_n1 got %b exp 1", clr_rdy); end
        tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL single_empty_n1 got %b exp 1", fifo_empty); end
        rx_rdy = 1'b0;
        @(negedge clk);
        tests++; if (clr_rdy !== 1'b0) begin fails++; $display("FAIL single_clr_n2 got %b exp 0", clr_rdy); end
        tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL single_empty_n2 got %b exp 0", fifo_empty); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count got %0d exp 1", count); end
        tests++; if (rd_data !== 8'hA5) begin fails++; $display("FAIL single_data got %h exp a5", rd_data); end
        @(negedge clk);
        pop_one();
        tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL single_pop_empty got %b exp 1", fifo_empty); end
        tests++; if (rd_data !== 8'hA5) begin fails++; $display("FAIL single_hold got %h exp a5", rd_data); end
        pop_one();
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL single_empty_pop got %0d exp 0", count); end
    endtask
    task automatic test_fill();
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", fifo_full); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL fill_ovr_pre got %b exp 0", overrun); end
        send_byte(8'h05);
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL fill_ovr got %b exp 1", overrun); end
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d exp 4", count); end
        for (int i = 1; i <= 4; i++) begin
            tests++; if (rd_data !== 8'(i)) begin fails++; $display("FAIL fill_read%0d got %h exp %h", i, rd_data, 8'(i)); end
            pop_one();
        end
        tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL fill_drained got %b exp 1", fifo_empty); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL fill_ovr_sticky got %b exp 1", overrun); end
        ovr_clr = 1'b1; @(negedge clk); ovr_clr = 1'b0;
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL fill_ovr_clr got %b exp 0", overrun); end
    endtask
    task automatic test_sticky();
        int extra = 0;
        rx_rdy = 1'b1; rx_data = 8'h3C;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 5; i++) begin extra += int'(clr_rdy); @(negedge clk); end
        rx_rdy = 1'b0;
        @(negedge clk); @(negedge clk);
        tests++; if (extra !== 0) begin fails++; $display("FAIL sticky_extra_clr got %0d exp 0", extra); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL sticky_count got %0d exp 1", count); end
        tests++; if (rd_data !== 8'h3C) begin fails++; $display("FAIL sticky_data got %h exp 3c", rd_data); end
        pop_one();
    endtask
    task automatic test_simul();
        send_byte(8'h10); send_byte(8'h20);
        rx_rdy = 1'b1; rx_data = 8'h30;
        @(negedge clk);
        tests++; if (clr_rdy !== 1'b1) begin fails++; $display("FAIL simul_capture2 got %b exp 1", clr_rdy); end
        rd_en = 1'b1; rx_rdy = 1'b0;
        @(negedge clk); rd_en = 1'b0;
        tests++; if (count !== 3'd2) begin fails++; $display("FAIL simul_count2 got %0d exp 2", count); end
        tests++; if (rd_data !== 8'h20) begin fails++; $display("FAIL simul_head2 got %h exp 20", rd_data); end
        @(negedge clk);
        pop_one();
        tests++; if (rd_data !== 8'h30) begin fails++; $display("FAIL simul_tail got %h exp 30", rd_data); end
        pop_one();
        rx_rdy = 1'b1; rx_data = 8'h40;
        @(negedge clk);
        tests++; if (clr_rdy !== 1'b1) begin fails++; $display("FAIL simul_capture0 got %b exp 1", clr_rdy); end
        rd_en = 1'b1; rx_rdy = 1'b0;
        @(negedge clk); rd_en = 1'b0;
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL simul_count0 got %0d exp 1", count); end
        tests++; if (rd_data !== 8'h40) begin fails++; $display("FAIL simul_keep got %h exp 40", rd_data); end
        @(negedge clk);
        pop_one();
    endtask
    task automatic test_mid_reset();
        send_byte(8'h51); send_byte(8'h52);
        rx_rdy = 1'b1; rx_data = 8'h53;
        @(negedge clk); @(negedge clk);
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL midrst_pre_count got %0d exp 3", count); end
        rst = 1'b1; rx_rdy = 1'b0;
        @(negedge clk);
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL midrst_count got %0d exp 0", count); end
        tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL midrst_empty got %b exp 1", fifo_empty); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL midrst_ovr got %b exp 0", overrun); end
        tests++; if (clr_rdy !== 1'b0) begin fails++; $display("FAIL midrst_clr got %b exp 0", clr_rdy); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (brg_en !== 1'b1) begin fails++; $display("FAIL midrst_brg1 got %b exp 1", brg_en); end
        @(negedge clk);
        tests++; if (brg_en !== 1'b0) begin fails++; $display("FAIL midrst_brg2 got %b exp 0", brg_en); end
        @(negedge clk);
        tests++; if (brg_en !== 1'b1) begin fails++; $display("FAIL midrst_brg3 got %b exp 1", brg_en); end
        send_byte(8'h66);
        tests++; if (rd_data !== 8'h66) begin fails++; $display("FAIL midrst_after got %h exp 66", rd_data); end
    endtask
    initial begin
        test_reset();
        test_baud();
        test_single();
        test_fill();
        test_sticky();
        test_simul();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
